// File: rtl/accumulator_scheduler_if.sv
// Client-side bundle of the accumulator scheduler: requests, burst data and completion.
interface accumulator_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ*DATA_W-1:0] in_data;
  logic [NUM_REQ-1:0]        in_valid;
  logic [NUM_REQ-1:0]        in_ready;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         result;
  logic                      busy;

  modport master (
    output req, req_len, in_data, in_valid,
    input  in_ready, grant, done, result, busy
  );

  modport slave (
    input  req, req_len, in_data, in_valid,
    output in_ready, grant, done, result, busy
  );
endinterface

// File: rtl/accumulator_scheduler.sv
// Round-robin owner of one shared accumulator: clears it, streams the winner's burst
// into it and returns the sum with a one-cycle done pulse.
//
// state | meaning
// IDLE  | arbitrate among req, latch owner and burst length
// CLEAR | owner granted, accumulator held in reset
// ACCUM | owner's beats accepted into the accumulator
// DONE  | accumulator final; captured into result on exit
module accumulator_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8,
  parameter int DATA_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  accumulator_scheduler_if.slave cli,
  output logic                  acc_clear,
  output logic                  acc_enable,
  output logic [DATA_W-1:0]     acc_data,
  input  logic [DATA_W-1:0]     acc_value
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DONE} state_e;

  state_e             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      last_q, last_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [DATA_W-1:0]  result_q, result_d;

  logic [OW-1:0] pick;
  logic          pick_vld;
  logic          beat;

  // Search starts one past the previous owner, so the last winner has lowest priority.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!pick_vld && cli.req[idx]) begin
        pick     = OW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign beat = (state_q == ACCUM) && cli.in_valid[owner_q];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    done_d   = '0;
    ready_d  = ready_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          len_d   = cli.req_len[int'(pick)*LEN_W +: LEN_W];
          grant_d = NUM_REQ'(1) << pick;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d = '0;
        if (len_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = ACCUM;
          ready_d = grant_q;
        end
      end
      ACCUM: begin
        if (beat) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = DONE;
            ready_d = '0;
          end
        end
      end
      DONE: begin
        result_d = acc_value;
        done_d   = grant_q;
        grant_d  = '0;
        last_d   = owner_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= OW'(NUM_REQ - 1);
      len_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      ready_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign acc_clear  = reset || (state_q == CLEAR);
  assign acc_enable = beat && !reset;
  assign acc_data   = cli.in_data[int'(owner_q)*DATA_W +: DATA_W];

  assign cli.in_ready = ready_q;
  assign cli.grant    = grant_q;
  assign cli.done     = done_q;
  assign cli.result   = result_q;
  assign cli.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_accumulator_scheduler.sv
// Bench for accumulator_scheduler: directed vector table, hand-written corner sequences
// and randomized bursts checked against a burst-level round-robin/sum model.
module tb_accumulator_scheduler;
  localparam int NUM_REQ = 4;
  localparam int LEN_W   = 8;
  localparam int DATA_W  = 16;

  typedef logic [DATA_W-1:0] word_t;
  typedef struct {
    int        rq;
    int        len;
    word_t     w[4];
    bit [7:0]  vpat;
    int        npat;
    word_t     exp_res;
    int        exp_lat;
  } vec_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  acc_clear, acc_enable;
  word_t acc_data, acc_model;

  always #5 clk = ~clk;

  accumulator_scheduler_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .DATA_W(DATA_W)) cli ();

  accumulator_scheduler #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cli        (cli),
    .acc_clear  (acc_clear),
    .acc_enable (acc_enable),
    .acc_data   (acc_data),
    .acc_value  (acc_model)
  );

  // Stand-in for the external Accumulator instance.
  always @(posedge clk)
    acc_model <= acc_clear ? '0 : (acc_enable ? word_t'(acc_model + acc_data) : acc_model);

  word_t src_q[NUM_REQ][$];
  bit    vpat_q[NUM_REQ][$];
  bit    pending[NUM_REQ];
  word_t exp_sum[NUM_REQ];
  int    exp_len[NUM_REQ];
  int    launch_tick[NUM_REQ];

  int checks = 0, errors = 0;
  int tick_no = 0, model_last = NUM_REQ - 1, cur_owner = 0;
  int en_cnt = 0, bursts_done = 0, last_lat = 0;
  bit rand_valid = 1'b0;
  logic [NUM_REQ-1:0] grant_prev = '0;
  int    grant_log[$];
  word_t result_log[$];
  vec_t  vecs[5];

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", name, act, exp, tick_no);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r);
    for (int k = 1; k <= NUM_REQ; k++)
      if (r[(model_last + k) % NUM_REQ]) return (model_last + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  function automatic vec_t mk_vec(input int rq, input int len, input word_t w0, input word_t w1,
                                  input word_t w2, input word_t w3, input bit [7:0] vpat,
                                  input int npat, input word_t res, input int lat);
    vec_t v;
    v.rq = rq; v.len = len;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.vpat = vpat; v.npat = npat; v.exp_res = res; v.exp_lat = lat;
    return v;
  endfunction

  // Caller fills src_q[r] (and optionally vpat_q[r]) first.
  task automatic launch(input int r);
    word_t s;
    s = '0;
    for (int j = 0; j < src_q[r].size(); j++) s = s + src_q[r][j];
    exp_sum[r]     = s;
    exp_len[r]     = src_q[r].size();
    launch_tick[r] = tick_no;
    pending[r]     = 1'b1;
    cli.req_len[r*LEN_W +: LEN_W] = LEN_W'(exp_len[r]);
    cli.req[r] = 1'b1;
  endtask

  task automatic tick();
    logic [NUM_REQ-1:0] req_seen, one, exp_mask;
    int exp_o;
    bit v;
    one = NUM_REQ'(1);
    @(negedge clk);
    req_seen = cli.req;
    tick_no++;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (cli.in_ready[r]) begin
        if (src_q[r].size() > 0) begin
          if (vpat_q[r].size() > 0) v = vpat_q[r].pop_front();
          else if (rand_valid)      v = ($urandom_range(0, 3) != 0);
          else                      v = 1'b1;
          cli.in_valid[r] = v;
          cli.in_data[r*DATA_W +: DATA_W] = src_q[r][0];
        end else begin
          cli.in_valid[r] = 1'b0;
        end
      end else begin
        cli.in_valid[r] = 1'($urandom_range(0, 1));
        cli.in_data[r*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
    end
    #1;
    check("ready_mask", (cli.in_ready & ~cli.grant) == '0, cli.in_ready, cli.grant);
    if (cli.grant != '0 && grant_prev == '0) begin
      exp_o    = rr_pick(req_seen);
      exp_mask = (exp_o >= 0) ? (one << exp_o) : '0;
      check("rr_grant", exp_o >= 0 && cli.grant == exp_mask, cli.grant, exp_mask);
      cur_owner = (exp_o >= 0) ? exp_o : onehot_idx(cli.grant);
      if (cur_owner < 0) cur_owner = 0;
      grant_log.push_back(onehot_idx(cli.grant));
      cli.req[cur_owner] = 1'b0;
      en_cnt = 0;
    end
    for (int r = 0; r < NUM_REQ; r++)
      if (cli.in_ready[r] && cli.in_valid[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
    if (acc_enable) en_cnt++;
    if (cli.done != '0) begin
      check("done_onehot", cli.done == (one << cur_owner), cli.done, one << cur_owner);
      check("done_pending", pending[cur_owner], pending[cur_owner], 1);
      check("result_sum", cli.result == exp_sum[cur_owner], cli.result, exp_sum[cur_owner]);
      check("beats_used", src_q[cur_owner].size() == 0, src_q[cur_owner].size(), 0);
      check("enable_count", en_cnt == exp_len[cur_owner], en_cnt, exp_len[cur_owner]);
      last_lat = tick_no - launch_tick[cur_owner];
      pending[cur_owner] = 1'b0;
      model_last = cur_owner;
      bursts_done++;
      result_log.push_back(cli.result);
    end
    grant_prev = cli.grant;
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b1;
    cli.req = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      src_q[r].delete();
      vpat_q[r].delete();
      pending[r] = 1'b0;
    end
    model_last = NUM_REQ - 1;
    repeat (n) begin
      tick();
      check("rst_acc_clear", acc_clear == 1'b1, acc_clear, 1);
      check("rst_grant", cli.grant == '0, cli.grant, 0);
      check("rst_done", cli.done == '0, cli.done, 0);
      check("rst_busy", cli.busy == 1'b0, cli.busy, 0);
      check("rst_result", cli.result == '0, cli.result, 0);
    end
    reset = 1'b0;
    model_last = NUM_REQ - 1;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (bursts_done < target && n < budget) begin
      tick();
      n++;
    end
    check("wait_done", bursts_done >= target, bursts_done, target);
  endtask

  initial begin
    int start, n, launched, len;
    vec_t v;
    cli.req = '0; cli.req_len = '0; cli.in_data = '0; cli.in_valid = '0;

    vecs[0] = mk_vec(0, 4, 16'd1, 16'd2, 16'd3, 16'd4, 8'h00, 0, 16'd10, 7);
    vecs[1] = mk_vec(1, 2, 16'hFFFF, 16'h0002, 16'd0, 16'd0, 8'h00, 0, 16'h0001, 5);
    vecs[2] = mk_vec(2, 3, 16'd7, 16'd8, 16'd9, 16'd0, 8'h29, 6, 16'd24, 9);
    vecs[3] = mk_vec(3, 0, 16'd0, 16'd0, 16'd0, 16'd0, 8'h00, 0, 16'd0, 3);
    vecs[4] = mk_vec(0, 1, 16'h1234, 16'd0, 16'd0, 16'd0, 8'h00, 0, 16'h1234, 4);

    do_reset(2);

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      for (int j = 0; j < v.len; j++) src_q[v.rq].push_back(v.w[j]);
      for (int j = 0; j < v.npat; j++) vpat_q[v.rq].push_back(v.vpat[j]);
      start = bursts_done;
      launch(v.rq);
      wait_done(start + 1, 100);
      check("vec_result", cli.result == v.exp_res, cli.result, v.exp_res);
      check("vec_latency", last_lat == v.exp_lat, last_lat, v.exp_lat);
    end

    // All four requesting at once after reset, then 0 and 1 together.
    do_reset(1);
    grant_log.delete();
    result_log.delete();
    start = bursts_done;
    for (int r = 0; r < NUM_REQ; r++) begin
      src_q[r].push_back(word_t'(r + 1));
      launch(r);
    end
    wait_done(start + 4, 200);
    for (int i = 0; i < 4; i++) begin
      check("rr_order", (i < grant_log.size() ? grant_log[i] : -1) == i,
            (i < grant_log.size() ? grant_log[i] : -1), i);
      check("rr_result", (i < result_log.size() ? result_log[i] : 16'hDEAD) == word_t'(i + 1),
            (i < result_log.size() ? result_log[i] : 16'hDEAD), i + 1);
    end
    src_q[0].push_back(16'd5);
    src_q[1].push_back(16'd6);
    launch(0);
    launch(1);
    wait_done(start + 6, 100);
    check("rr_pair_first", (grant_log.size() > 4 ? grant_log[4] : -1) == 0,
          (grant_log.size() > 4 ? grant_log[4] : -1), 0);
    check("rr_pair_second", (grant_log.size() > 5 ? grant_log[5] : -1) == 1,
          (grant_log.size() > 5 ? grant_log[5] : -1), 1);

    // Reset in the middle of an accumulate phase.
    en_cnt = 0;
    src_q[2] = '{16'd100, 16'd200, 16'd300, 16'd400};
    launch(2);
    n = 0;
    while (en_cnt < 2 && n < 50) begin
      tick();
      n++;
    end
    check("reached_accum", en_cnt >= 2, en_cnt, 2);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_done_after_reset", cli.done == '0 && cli.busy == 1'b0, cli.done, 0);
    end
    start = bursts_done;
    src_q[1] = '{16'd5, 16'd6};
    launch(1);
    wait_done(start + 1, 100);
    check("post_reset_sum", cli.result == 16'd11, cli.result, 11);

    // Randomized bursts with random valid gaps and junk on non-granted lanes.
    rand_valid = 1'b1;
    launched = 0;
    start = bursts_done;
    n = 0;
    while ((launched < 60 || bursts_done < start + launched) && n < 20000) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!pending[r] && launched < 60 && $urandom_range(0, 5) == 0) begin
          len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(0, 6));
          for (int j = 0; j < len; j++) src_q[r].push_back(DATA_W'($urandom));
          launch(r);
          launched++;
        end
      end
      tick();
      n++;
    end
    check("random_drain", bursts_done == start + launched, bursts_done, start + launched);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
